// File: rtl/code_entry_ctrl.sv
// rtl/code_entry_ctrl.sv - keypad code entry controller: collects four hex digits, loads them, awaits grant, locks out after repeated failures
module code_entry_ctrl #(
  parameter int TIMEOUT     = 1000,
  parameter int HOLD_CYCLES = 16,
  parameter int LOCK_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        key_enter,
  input  logic        key_clear,
  input  logic        Access_Grant,
  output logic [15:0] Data_In,
  output logic        Data_In_Load,
  output logic [2:0]  digit_count,
  output logic        entry_error,
  output logic        locked,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_LOAD,
    S_HOLD,
    S_LOCKOUT
  } state_t;

  // Terminal values of the shared cycle timer for each timed state.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] HOLD_LAST    = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] LOCK_LAST    = 16'(LOCK_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] timer, timer_nxt;
  logic [1:0]  fail_cnt, fail_cnt_nxt;
  logic [15:0] data_nxt;
  logic [2:0]  count_nxt;
  logic        err_nxt;
  logic        load_nxt;
  logic        locked_nxt;
  logic        busy_nxt;

  // Next-state, datapath and registered-output values; one timer serves COLLECT, HOLD and LOCKOUT.
  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    fail_cnt_nxt = fail_cnt;
    data_nxt     = Data_In;
    count_nxt    = digit_count;
    err_nxt      = 1'b0;

    case (state)
      S_IDLE: begin
        if (key_valid) begin
          data_nxt  = {12'h000, key_code};
          count_nxt = 3'd1;
          timer_nxt = '0;
          state_nxt = S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (key_clear) begin
          data_nxt  = '0;
          count_nxt = '0;
          timer_nxt = '0;
          state_nxt = S_IDLE;
        end else if (key_enter) begin
          timer_nxt = '0;
          if (digit_count == 3'd4) begin
            state_nxt = S_LOAD;
          end else begin
            err_nxt   = 1'b1;
            data_nxt  = '0;
            count_nxt = '0;
            state_nxt = S_IDLE;
          end
        end else if (key_valid) begin
          timer_nxt = '0;
          if (digit_count != 3'd4) begin
            data_nxt  = {Data_In[11:0], key_code};
            count_nxt = digit_count + 3'd1;
          end
        end else if (timer == TIMEOUT_LAST) begin
          err_nxt   = 1'b1;
          data_nxt  = '0;
          count_nxt = '0;
          timer_nxt = '0;
          state_nxt = S_IDLE;
        end else begin
          timer_nxt = timer + 16'd1;
        end
      end

      S_LOAD: begin
        timer_nxt = '0;
        state_nxt = S_HOLD;
      end

      S_HOLD: begin
        // A grant arriving on the timeout cycle still wins.
        if (Access_Grant) begin
          fail_cnt_nxt = '0;
          data_nxt     = '0;
          count_nxt    = '0;
          timer_nxt    = '0;
          state_nxt    = S_IDLE;
        end else if (timer == HOLD_LAST) begin
          err_nxt      = 1'b1;
          data_nxt     = '0;
          count_nxt    = '0;
          timer_nxt    = '0;
          fail_cnt_nxt = (fail_cnt == 2'd3) ? 2'd3 : fail_cnt + 2'd1;
          state_nxt    = (fail_cnt_nxt == 2'd3) ? S_LOCKOUT : S_IDLE;
        end else begin
          timer_nxt = timer + 16'd1;
        end
      end

      S_LOCKOUT: begin
        if (timer == LOCK_LAST) begin
          fail_cnt_nxt = '0;
          timer_nxt    = '0;
          state_nxt    = S_IDLE;
        end else begin
          timer_nxt = timer + 16'd1;
        end
      end

      default: begin
        data_nxt  = '0;
        count_nxt = '0;
        timer_nxt = '0;
        state_nxt = S_IDLE;
      end
    endcase

    load_nxt   = (state_nxt == S_LOAD);
    locked_nxt = (state_nxt == S_LOCKOUT);
    busy_nxt   = (state_nxt == S_LOAD) || (state_nxt == S_HOLD) || (state_nxt == S_LOCKOUT);
  end

  // State, counters and all outputs are registered; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      timer        <= '0;
      fail_cnt     <= '0;
      Data_In      <= '0;
      digit_count  <= '0;
      entry_error  <= 1'b0;
      Data_In_Load <= 1'b0;
      locked       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      fail_cnt     <= fail_cnt_nxt;
      Data_In      <= data_nxt;
      digit_count  <= count_nxt;
      entry_error  <= err_nxt;
      Data_In_Load <= load_nxt;
      locked       <= locked_nxt;
      busy         <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_code_entry_ctrl.sv
// tb/tb_code_entry_ctrl.sv - randomized self-checking bench for code_entry_ctrl against a behavioural model
module tb_code_entry_ctrl;
  localparam int TIMEOUT     = 20;
  localparam int HOLD_CYCLES = 6;
  localparam int LOCK_CYCLES = 30;

  logic        clk;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_enter;
  logic        key_clear;
  logic        Access_Grant;
  logic [15:0] Data_In;
  logic        Data_In_Load;
  logic [2:0]  digit_count;
  logic        entry_error;
  logic        locked;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: digits in a queue, phases as countdowns.
  int m_digits[$];
  int m_idle;
  bit m_load;
  int m_hold_left;
  int m_lock_left;
  int m_fails;
  bit m_err;

  code_entry_ctrl #(
    .TIMEOUT    (TIMEOUT),
    .HOLD_CYCLES(HOLD_CYCLES),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_enter   (key_enter),
    .key_clear   (key_clear),
    .Access_Grant(Access_Grant),
    .Data_In     (Data_In),
    .Data_In_Load(Data_In_Load),
    .digit_count (digit_count),
    .entry_error (entry_error),
    .locked      (locked),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int m_value();
    int v = 0;
    foreach (m_digits[i]) v = v * 16 + m_digits[i];
    return v;
  endfunction

  function automatic bit m_in_entry();
    return (m_lock_left == 0) && !m_load && (m_hold_left == 0);
  endfunction

  task automatic model_reset();
    m_digits.delete();
    m_idle      = 0;
    m_load      = 0;
    m_hold_left = 0;
    m_lock_left = 0;
    m_fails     = 0;
    m_err       = 0;
  endtask

  task automatic model_step(input bit kv, input int kc, input bit ke, input bit kcl, input bit g);
    m_err = 0;
    if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (m_load) begin
      m_load      = 0;
      m_hold_left = HOLD_CYCLES;
    end else if (m_hold_left > 0) begin
      if (g) begin
        m_fails     = 0;
        m_hold_left = 0;
        m_digits.delete();
      end else begin
        m_hold_left--;
        if (m_hold_left == 0) begin
          m_err = 1;
          m_digits.delete();
          if (m_fails < 3) m_fails++;
          if (m_fails == 3) m_lock_left = LOCK_CYCLES;
        end
      end
    end else if (m_digits.size() == 0) begin
      if (kv) begin
        m_digits.push_back(kc);
        m_idle = 0;
      end
    end else begin
      if (kcl) begin
        m_digits.delete();
      end else if (ke) begin
        if (m_digits.size() == 4) m_load = 1;
        else begin
          m_err = 1;
          m_digits.delete();
        end
      end else if (kv) begin
        m_idle = 0;
        if (m_digits.size() < 4) m_digits.push_back(kc);
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          m_err = 1;
          m_digits.delete();
        end
      end
    end
  endtask

  task automatic compare_all(input string ctx);
    check({ctx, "_data"},   Data_In,      m_value());
    check({ctx, "_count"},  digit_count,  m_digits.size());
    check({ctx, "_load"},   Data_In_Load, m_load);
    check({ctx, "_err"},    entry_error,  m_err);
    check({ctx, "_locked"}, locked,       m_lock_left > 0);
    check({ctx, "_busy"},   busy,         m_load || (m_hold_left > 0) || (m_lock_left > 0));
  endtask

  task automatic cycle(input bit kv, input logic [3:0] kc, input bit ke, input bit kcl, input bit g);
    key_valid    = kv;
    key_code     = kc;
    key_enter    = ke;
    key_clear    = kcl;
    Access_Grant = g;
    @(posedge clk);
    model_step(kv, kc, ke, kcl, g);
    #1;
    compare_all("cyc");
  endtask

  task automatic press_code(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) cycle(1'b1, code[i*4 +: 4], 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    #1 rst = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    #1 rst = 1'b1;
  endtask

  initial begin
    int n_locked;
    int dens;
    int r;
    bit kv, ke, kcl, g;

    rst          = 1'b0;
    key_valid    = 1'b0;
    key_code     = 4'h0;
    key_enter    = 1'b0;
    key_clear    = 1'b0;
    Access_Grant = 1'b0;
    model_reset();
    #1;
    compare_all("reset");
    @(posedge clk);
    #1;
    compare_all("reset_held");
    rst = 1'b1;

    // Full code load, then grant.
    press_code(16'h1476);
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    check("req033_load",  Data_In_Load, 1);
    check("req033_data",  Data_In,      16'h1476);
    check("req033_busy",  busy,         1);
    check("req033_count", digit_count,  4);
    cycle(1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
    check("req033_pulse",  Data_In_Load, 0);
    check("req033_stable", Data_In,      16'h1476);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    check("grant_idle", busy, 0);
    check("grant_data", Data_In, 0);

    // Fifth digit ignored.
    press_code(16'h4789);
    cycle(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    check("req034_data", Data_In,      16'h4789);
    check("req034_load", Data_In_Load, 1);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);

    // Short code rejected.
    cycle(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    check("req035_err",   entry_error,  1);
    check("req035_count", digit_count,  0);
    check("req035_load",  Data_In_Load, 0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("req035_pulse", entry_error, 0);

    // Inactivity timeout.
    cycle(1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++) cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("req036_pre_err",   entry_error, 0);
    check("req036_pre_count", digit_count, 1);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("req036_err",  entry_error, 1);
    check("req036_data", Data_In,     0);

    // Three ungranted loads lead to lockout.
    for (int k = 0; k < 3; k++) begin
      press_code(16'h2580 + 16'(k));
      cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < HOLD_CYCLES + 1; i++) cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      check("req037_err", entry_error, 1);
    end
    check("req037_locked", locked, 1);
    n_locked = locked ? 1 : 0;
    for (int i = 0; i < LOCK_CYCLES + 5; i++) begin
      cycle(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (!locked) break;
      n_locked++;
    end
    check("req037_lock_len", n_locked, LOCK_CYCLES);
    check("req037_unlocked", locked, 0);
    check("req037_count", digit_count, 0);

    // Reset in the middle of HOLD.
    press_code(16'hBEEF);
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("req038_pre_busy", busy, 1);
    do_reset();
    check("req038_data", Data_In, 0);
    check("req038_busy", busy, 0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    check("req038_grant_err", entry_error, 0);
    cycle(1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
    check("req032_accept", digit_count, 1);

    // Randomized traffic with varying strobe density and occasional reset.
    for (int seg = 0; seg < 20; seg++) begin
      dens = $urandom_range(5, 60);
      for (int i = 0; i < 200; i++) begin
        r   = $urandom_range(0, 99);
        kv  = (r < dens);
        ke  = (r >= dens) && (r < dens + 6);
        kcl = (r >= dens + 6) && (r < dens + 7);
        if ($urandom_range(0, 24) == 0) begin
          kv  = 1'b1;
          ke  = 1'($urandom_range(0, 1));
          kcl = 1'($urandom_range(0, 1));
        end
        g = ($urandom_range(0, 9) == 0);
        cycle(kv, 4'($urandom_range(0, 15)), ke, kcl, g);
        if ($urandom_range(0, 499) == 0) do_reset();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
